// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and byte-lane patterns for the MIPS CPU Avalon-MM bus arbiter.
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } client_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE_0  = 4'b0001;
  localparam logic [3:0] BE_BYTE_1  = 4'b0010;
  localparam logic [3:0] BE_BYTE_2  = 4'b0100;
  localparam logic [3:0] BE_BYTE_3  = 4'b1000;

endpackage

// File: rtl/mips_cpu_bus_align_check.sv
// Decides whether a byte address / lane-enable pair forms a legal Avalon access.
module mips_cpu_bus_align_check
  import mips_cpu_bus_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [3:0] be,
  output logic       ok
);

  always_comb begin
    ok = 1'b0;
    unique case (be)
      BE_WORD:                 ok = (addr_lo == 2'b00);
      BE_HALF_LO, BE_HALF_HI:  ok = (addr_lo[0] == 1'b0);
      BE_BYTE_0, BE_BYTE_1,
      BE_BYTE_2, BE_BYTE_3:    ok = 1'b1;
      default:                 ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between the fetch and data clients.
// state | meaning
// IDLE  | waiting for a request; picks winner and checks alignment
// BUS   | read/write held on the bus until waitrequest drops or the wait bound expires
// RESP  | one-cycle ack/err pulse to the granted client; bus quiet
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  arb_state_t  state_q, state_d;
  client_t     grant_q, grant_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] address_q, address_d, writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        read_q, read_d, write_q, write_d;
  logic        i_ack_q, i_ack_d, i_err_q, i_err_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  client_t     win;
  logic [31:0] win_addr;
  logic [3:0]  win_be;
  logic        win_we;
  logic        win_ok;
  logic        bus_done;

  // grant_q doubles as the round-robin history: it always names the last winner
  always_comb begin
    if (i_req && d_req) win = (grant_q == CLIENT_D) ? CLIENT_I : CLIENT_D;
    else if (i_req)     win = CLIENT_I;
    else                win = CLIENT_D;
  end

  assign win_addr = (win == CLIENT_I) ? i_addr  : d_addr;
  assign win_be   = (win == CLIENT_I) ? BE_WORD : d_byteenable;
  assign win_we   = (win == CLIENT_D) && d_we;

  mips_cpu_bus_align_check u_align (
    .addr_lo (win_addr[1:0]),
    .be      (win_be),
    .ok      (win_ok)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ack_d      = 1'b0;
    i_err_d      = 1'b0;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    bus_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant_d = win;
          if (win_ok) begin
            state_d      = BUS;
            address_d    = win_addr;
            byteenable_d = win_be;
            writedata_d  = (win == CLIENT_D) ? d_wdata : 32'd0;
            read_d       = !win_we;
            write_d      = win_we;
            cnt_d        = 16'd0;
          end else begin
            state_d = RESP;
            i_err_d = (win == CLIENT_I);
            d_err_d = (win == CLIENT_D);
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          bus_done = 1'b1;
          i_ack_d  = (grant_q == CLIENT_I);
          d_ack_d  = (grant_q == CLIENT_D);
          if (read_q) begin
            if (grant_q == CLIENT_I) i_rdata_d = readdata;
            else                     d_rdata_d = readdata;
          end
        end else if (cnt_q == WAIT_LAST) begin
          bus_done = 1'b1;
          i_err_d  = (grant_q == CLIENT_I);
          d_err_d  = (grant_q == CLIENT_D);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus_done) begin
      state_d      = RESP;
      cnt_d        = 16'd0;
      read_d       = 1'b0;
      write_d      = 1'b0;
      address_d    = 32'd0;
      writedata_d  = 32'd0;
      byteenable_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= CLIENT_D;
      cnt_q        <= 16'd0;
      address_q    <= 32'd0;
      writedata_q  <= 32'd0;
      byteenable_q <= 4'd0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ack_q      <= i_ack_d;
      i_err_q      <= i_err_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
    end
  end

  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign read       = read_q;
  assign write      = write_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign i_ack      = i_ack_q;
  assign i_err      = i_err_q;
  assign d_ack      = d_ack_q;
  assign d_err      = d_err_q;

endmodule
